ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M-style multiply/divide unit.
//   Multiplies with a radix-2 shift-add over a 2*XLEN product register and
//   divides with a radix-2 restoring divider on unsigned magnitudes. The sign
//   of the result is reapplied when the last step completes. Divide-by-zero
//   and signed overflow skip the iterative phase and finish in one cycle.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake (funct3, opr_a, opr_b, rd)
//   flush               kill any in-flight operation (highest priority)
//   out_valid/out_ready result handshake (opr_res, out_rd)
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    input  logic [RD_W-1:0] rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] opr_res,
    output logic [RD_W-1:0] out_rd
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        op_reg;
    logic [RD_W-1:0]   rd_reg;
    logic              neg_reg;     // negate the final product / quotient / remainder
    logic [XLEN-1:0]   opnd_reg;    // multiplicand magnitude or divisor magnitude
    logic [2*XLEN-1:0] acc_reg;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opr_res_reg;
    logic [RD_W-1:0]   out_rd_reg;

    // Request decode
    logic              accept;
    logic              is_div;
    logic              signed_a;
    logic              signed_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;

    always_comb begin
        accept   = in_valid && in_ready;
        is_div   = funct3[2];
        // DIV/REM signed, DIVU/REMU unsigned; MULHSU has signed a, unsigned b.
        signed_a = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
        signed_b = is_div ? !funct3[0] : !funct3[1];
        neg_a    = signed_a && opr_a[XLEN-1];
        neg_b    = signed_b && opr_b[XLEN-1];
        mag_a    = neg_a ? (~opr_a + 1'b1) : opr_a;
        mag_b    = neg_b ? (~opr_b + 1'b1) : opr_b;
        div_zero = is_div && (opr_b == '0);
        div_ovf  = is_div && !funct3[0] && (opr_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (opr_b == '1);
        if (div_zero)
            special_res = funct3[1] ? opr_a : '1;
        else
            special_res = funct3[1] ? '0 : opr_a;
    end

    // One radix-2 step and the final sign fix-up
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {acc_reg, 1'b0};
        div_trial = div_shift[2*XLEN:XLEN] - {1'b0, opnd_reg};
        if (!op_reg[2]) begin
            step_acc = {mul_sum, acc_reg[XLEN-1:1]};
        end else begin
            step_acc = div_shift[2*XLEN-1:0];
            // No borrow: divisor fits, keep the difference and set the quotient bit.
            if (!div_trial[XLEN]) begin
                step_acc[2*XLEN-1:XLEN] = div_trial[XLEN-1:0];
                step_acc[0]             = 1'b1;
            end
        end
        prod_signed = neg_reg ? (~step_acc + 1'b1) : step_acc;
        quo_signed  = neg_reg ? (~step_acc[XLEN-1:0] + 1'b1) : step_acc[XLEN-1:0];
        rem_signed  = neg_reg ? (~step_acc[2*XLEN-1:XLEN] + 1'b1) : step_acc[2*XLEN-1:XLEN];
        if (!op_reg[2])
            fin_res = (op_reg[1:0] == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
        else
            fin_res = op_reg[1] ? rem_signed : quo_signed;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            rd_reg      <= '0;
            neg_reg     <= 1'b0;
            opnd_reg    <= '0;
            acc_reg     <= '0;
            opr_res_reg <= '0;
            out_rd_reg  <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg   <= funct3;
                        rd_reg   <= rd;
                        cnt_reg  <= '0;
                        opnd_reg <= is_div ? mag_b : mag_a;
                        acc_reg  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        // Remainder takes the dividend's sign; everything else the xor.
                        neg_reg  <= (is_div && funct3[1]) ? neg_a : (neg_a ^ neg_b);
                        if (div_zero || div_ovf) begin
                            opr_res_reg <= special_res;
                            out_rd_reg  <= rd;
                            state_reg   <= DONE;
                        end else begin
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_reg <= step_acc;
                    if (cnt_reg == CW'(XLEN-1)) begin
                        opr_res_reg <= fin_res;
                        out_rd_reg  <= rd_reg;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !flush;
    assign out_valid = (state_reg == DONE);
    assign opr_res   = opr_res_reg;
    assign out_rd    = out_rd_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (XLEN = 32): a driver issues directed
// requests and queues the hand-computed result, rd and latency; a monitor
// compares each presented result against the head of the queue.
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] opr_a;
    logic [XLEN-1:0] opr_b;
    logic [RD_W-1:0] rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] opr_res;
    logic [RD_W-1:0] out_rd;

    ex_muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .opr_a(opr_a), .opr_b(opr_b), .rd(rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .opr_res(opr_res), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [XLEN-1:0] res;
        logic [RD_W-1:0] rd;
        int              lat;
        int              acc_cyc;
    } item_t;

    item_t sb_q[$];
    int    cyc    = 0;
    int    errors = 0;
    int    checks = 0;
    bit    seen   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: latency on first sighting of out_valid, data on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got res 0x%08h rd %0d with empty scoreboard",
                         opr_res, out_rd);
            end else begin
                if (!seen) begin
                    chk({sb_q[0].name, "_lat"}, XLEN'(cyc - sb_q[0].acc_cyc), XLEN'(sb_q[0].lat));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    chk({sb_q[0].name, "_res"}, opr_res, sb_q[0].res);
                    chk({sb_q[0].name, "_rd"}, XLEN'(out_rd), XLEN'(sb_q[0].rd));
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [RD_W-1:0] r,
                         input logic [XLEN-1:0] exp, input int lat, input bit push);
        int    n;
        item_t it;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        funct3   = f3;
        opr_a    = a;
        opr_b    = b;
        rd       = r;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready stayed 0 for 200 cycles, required 1", name);
        end else if (push) begin
            it.name = name; it.res = exp; it.rd = r; it.lat = lat; it.acc_cyc = cyc;
            sb_q.push_back(it);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operand changes while busy must be ignored.
        opr_a  = 32'h5A5A5A5A;
        opr_b  = 32'h00000003;
        funct3 = 3'b000;
        rd     = 5'd31;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; funct3 = '0; opr_a = '0; opr_b = '0; rd = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", XLEN'(out_valid), 32'd0);
        chk("rst_opr_res", opr_res, 32'd0);
        chk("rst_out_rd", XLEN'(out_rd), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", XLEN'(in_ready), 32'd1);

        // Multiply
        issue("mul_7xm3",   3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33, 1'b1); drain("mul_7xm3");
        issue("mulhu_ff",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33, 1'b1); drain("mulhu_ff");
        issue("mulh_ff",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 33, 1'b1); drain("mulh_ff");
        issue("mulhsu_ff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33, 1'b1); drain("mulhsu_ff");
        issue("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 33, 1'b1); drain("mulh_min");
        // Divide
        issue("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 33, 1'b1); drain("div_m7_2");
        issue("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 33, 1'b1); drain("rem_m7_2");
        issue("divu_100_7", 3'b101, 32'd100,      32'd7,        5'd8,  32'd14,       33, 1'b1); drain("divu_100_7");
        issue("remu_100_7", 3'b111, 32'd100,      32'd7,        5'd9,  32'd2,        33, 1'b1); drain("remu_100_7");
        issue("div_7_m2",   3'b100, 32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33, 1'b1); drain("div_7_m2");
        issue("rem_7_m2",   3'b110, 32'd7,        32'hFFFFFFFE, 5'd11, 32'd1,        33, 1'b1); drain("rem_7_m2");
        // Special cases
        issue("divu_5_0",   3'b101, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1,  1'b1); drain("divu_5_0");
        issue("rem_5_0",    3'b110, 32'd5,        32'd0,        5'd13, 32'd5,        1,  1'b1); drain("rem_5_0");
        issue("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1,  1'b1); drain("div_ovf");
        issue("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1,  1'b1); drain("rem_ovf");

        // Backpressure
        @(posedge clk); #1 out_ready = 1'b0;
        issue("bp_divu", 3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 33, 1'b1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", i), XLEN'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_res", i), opr_res, 32'd14);
            chk($sformatf("bp_hold%0d_rd", i), XLEN'(out_rd), 32'd16);
            chk($sformatf("bp_hold%0d_in_ready", i), XLEN'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", XLEN'(in_ready), 32'd1);
        drain("bp_divu");

        // Flush 10 cycles into BUSY
        issue("flush_div", 3'b101, 32'd1000, 32'd3, 5'd20, 32'd333, 33, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", XLEN'(out_valid), 32'd0);
        chk("flush_in_ready", XLEN'(in_ready), 32'd1);
        issue("post_flush_mul", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33, 1'b1);
        drain("post_flush_mul");

        // Reset mid-BUSY
        issue("rst_busy", 3'b000, 32'd9, 32'd9, 5'd22, 32'd81, 33, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy_out_valid", XLEN'(out_valid), 32'd0);
        chk("rst_busy_in_ready", XLEN'(in_ready), 32'd1);
        chk("rst_busy_opr_res", opr_res, 32'd0);
        repeat (40) @(negedge clk);
        issue("post_rst_remu", 3'b111, 32'd1000, 32'd3, 5'd23, 32'd1, 33, 1'b1);
        drain("post_rst_remu");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
